// File: rtl/bloc_setare_pkg.sv
// Shared constants for the clock time-keeping block: state encoding, packed
// time-word field offsets and BCD field limits.
package bloc_setare_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;
    localparam int EDIT_BIT = 24;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

endpackage

// File: rtl/bloc_setare_debounce_btn.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability-count
// debouncer that emits a single-cycle pulse on each accepted press.
module debounce_btn #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            btn_pulse <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_p1 != btn_level) begin
                if (cnt == CNT_LAST) begin
                    cnt       <= '0;
                    btn_level <= sync_p1;
                    btn_pulse <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bloc_setare.sv
// HH:MM:SS BCD time-keeper with button-driven field editing; produces the
// packed time word consumed by the 7-segment display multiplexer.
module bloc_setare
    import bloc_setare_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [24:0] data_out,
    output logic [1:0]  edit_sel
);

    // Wraps at max_v going up and to max_v going down; digits stay within 0..9.
    function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                            input logic [7:0] max_v,
                                            input logic       up);
        logic [7:0] r;
        if (up) begin
            if (v == max_v)         r = 8'h00;
            else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
            else                    r = v + 8'd1;
        end else begin
            if (v == 8'h00)         r = max_v;
            else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
            else                    r = v - 8'd1;
        end
        return r;
    endfunction

    logic       mode_p, up_p, down_p;
    logic [2:0] unused_levels;

    debounce_btn #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_mode (
        .clock(clock), .reset(reset), .btn_raw(btn_mode),
        .btn_level(unused_levels[0]), .btn_pulse(mode_p)
    );
    debounce_btn #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_up (
        .clock(clock), .reset(reset), .btn_raw(btn_up),
        .btn_level(unused_levels[1]), .btn_pulse(up_p)
    );
    debounce_btn #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_down (
        .clock(clock), .reset(reset), .btn_raw(btn_down),
        .btn_level(unused_levels[2]), .btn_pulse(down_p)
    );

    state_t     state;
    logic [7:0] hours, mins, secs;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            hours <= 8'h00;
            mins  <= 8'h00;
            secs  <= 8'h00;
        end else begin
            // A mode press swallows any up/down arriving in the same cycle.
            if (mode_p) begin
                case (state)
                    RUN:     state <= SET_H;
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= RUN;
                endcase
            end else if (up_p ^ down_p) begin
                case (state)
                    SET_H:   hours <= bcd_step(hours, HOUR_MAX, up_p);
                    SET_M:   mins  <= bcd_step(mins,  MIN_MAX,  up_p);
                    SET_S:   secs  <= bcd_step(secs,  MIN_MAX,  up_p);
                    default: ;
                endcase
            end

            // Time only advances while running, judged on the current state.
            if (state == RUN && tick_1hz) begin
                secs <= bcd_step(secs, MIN_MAX, 1'b1);
                if (secs == MIN_MAX) begin
                    mins <= bcd_step(mins, MIN_MAX, 1'b1);
                    if (mins == MIN_MAX)
                        hours <= bcd_step(hours, HOUR_MAX, 1'b1);
                end
            end
        end
    end

    assign edit_sel                   = state;
    assign data_out[EDIT_BIT]         = (state != RUN);
    assign data_out[HOUR_LSB +: 8]    = hours;
    assign data_out[MIN_LSB +: 8]     = mins;
    assign data_out[SEC_LSB +: 8]     = secs;

endmodule
